// File: rtl/id_stage.sv
// ============================================================================
//  Module   : id_stage
//  Purpose  : RV32I instruction-decode stage. Decodes one instruction per
//             cycle, drives both regfile read ports, forwards EX/MEM results
//             over regfile data, detects load-use hazards and holds the
//             registered ID/EX outputs consumed by EX.
//  Ports    : clk, rst (sync, active-high), rdy (global freeze)
//             in_valid/in_pc/in_inst    : IF/ID contents
//             flush, ex_stall           : control from EX
//             stall_req                 : to IF, hold IF/ID (combinational)
//             re1/re2, raddr1/2, rdata1/2 : regfile read ports
//             ex_* / mem_*              : forwarding sources
//             out_*                     : registered ID/EX slot
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_valid,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [31:0]           in_inst,
    input  logic                  flush,
    input  logic                  ex_stall,
    output logic                  stall_req,
    output logic                  re1,
    output logic                  re2,
    output logic [REG_ADDR_W-1:0] raddr1,
    output logic [REG_ADDR_W-1:0] raddr2,
    input  logic [XLEN-1:0]       rdata1,
    input  logic [XLEN-1:0]       rdata2,
    input  logic                  ex_wreg,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic [XLEN-1:0]       ex_wdata,
    input  logic                  ex_is_load,
    input  logic                  mem_wreg,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic [XLEN-1:0]       mem_wdata,
    output logic                  out_valid,
    output logic [XLEN-1:0]       out_pc,
    output logic [5:0]            out_op,
    output logic [XLEN-1:0]       out_rs1_val,
    output logic [XLEN-1:0]       out_rs2_val,
    output logic [XLEN-1:0]       out_imm,
    output logic                  out_wreg,
    output logic [REG_ADDR_W-1:0] out_waddr
);

    // Operation codes handed to EX
    localparam logic [5:0] OP_NOP  = 6'd0,  OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,
                           OP_JAL  = 6'd3,  OP_JALR = 6'd4,  OP_BEQ   = 6'd5,
                           OP_BNE  = 6'd6,  OP_BLT  = 6'd7,  OP_BGE   = 6'd8,
                           OP_BLTU = 6'd9,  OP_BGEU = 6'd10, OP_LB    = 6'd11,
                           OP_LH   = 6'd12, OP_LW   = 6'd13, OP_LBU   = 6'd14,
                           OP_LHU  = 6'd15, OP_SB   = 6'd16, OP_SH    = 6'd17,
                           OP_SW   = 6'd18, OP_ADDI = 6'd19, OP_SLTI  = 6'd20,
                           OP_SLTIU= 6'd21, OP_XORI = 6'd22, OP_ORI   = 6'd23,
                           OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI  = 6'd26,
                           OP_SRAI = 6'd27, OP_ADD  = 6'd28, OP_SUB   = 6'd29,
                           OP_SLL  = 6'd30, OP_SLT  = 6'd31, OP_SLTU  = 6'd32,
                           OP_XOR  = 6'd33, OP_SRL  = 6'd34, OP_SRA   = 6'd35,
                           OP_OR   = 6'd36, OP_AND  = 6'd37;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                           OPC_JAL = 7'b1101111, OPC_JALR  = 7'b1100111,
                           OPC_BR  = 7'b1100011, OPC_LOAD  = 7'b0000011,
                           OPC_ST  = 7'b0100011, OPC_OPIMM = 7'b0010011,
                           OPC_OP  = 7'b0110011;

    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [REG_ADDR_W-1:0] rd;
    logic [5:0]            dec_op;
    logic [XLEN-1:0]       dec_imm;
    logic                  dec_wr;
    logic                  use1;
    logic                  use2;
    logic                  lu;
    logic [XLEN-1:0]       fwd1;
    logic [XLEN-1:0]       fwd2;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign rd     = in_inst[11:7];

    always_comb begin
        dec_op  = OP_NOP;
        dec_imm = '0;
        dec_wr  = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_op = OP_LUI; dec_wr = 1'b1;
                dec_imm = {in_inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec_op = OP_AUIPC; dec_wr = 1'b1;
                dec_imm = {in_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec_op = OP_JAL; dec_wr = 1'b1;
                dec_imm = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                use1 = 1'b1;
                dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
                if (f3 == 3'b000) begin dec_op = OP_JALR; dec_wr = 1'b1; end
            end
            OPC_BR: begin
                use1 = 1'b1; use2 = 1'b1;
                dec_imm = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
                case (f3)
                    3'b000: dec_op = OP_BEQ;
                    3'b001: dec_op = OP_BNE;
                    3'b100: dec_op = OP_BLT;
                    3'b101: dec_op = OP_BGE;
                    3'b110: dec_op = OP_BLTU;
                    3'b111: dec_op = OP_BGEU;
                    default: dec_op = OP_NOP;
                endcase
            end
            OPC_LOAD: begin
                use1 = 1'b1; dec_wr = 1'b1;
                dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
                case (f3)
                    3'b000: dec_op = OP_LB;
                    3'b001: dec_op = OP_LH;
                    3'b010: dec_op = OP_LW;
                    3'b100: dec_op = OP_LBU;
                    3'b101: dec_op = OP_LHU;
                    default: begin dec_op = OP_NOP; dec_wr = 1'b0; end
                endcase
            end
            OPC_ST: begin
                use1 = 1'b1; use2 = 1'b1;
                dec_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                case (f3)
                    3'b000: dec_op = OP_SB;
                    3'b001: dec_op = OP_SH;
                    3'b010: dec_op = OP_SW;
                    default: dec_op = OP_NOP;
                endcase
            end
            OPC_OPIMM: begin
                use1 = 1'b1; dec_wr = 1'b1;
                dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
                case (f3)
                    3'b000: dec_op = OP_ADDI;
                    3'b010: dec_op = OP_SLTI;
                    3'b011: dec_op = OP_SLTIU;
                    3'b100: dec_op = OP_XORI;
                    3'b110: dec_op = OP_ORI;
                    3'b111: dec_op = OP_ANDI;
                    3'b001: dec_op = (f7 == 7'b0000000) ? OP_SLLI : OP_NOP;
                    default: dec_op = (f7 == 7'b0000000) ? OP_SRLI :
                                      (f7 == 7'b0100000) ? OP_SRAI : OP_NOP;
                endcase
                if (dec_op == OP_NOP) dec_wr = 1'b0;
            end
            OPC_OP: begin
                use1 = 1'b1; use2 = 1'b1; dec_wr = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: dec_op = OP_ADD;
                        3'b001: dec_op = OP_SLL;
                        3'b010: dec_op = OP_SLT;
                        3'b011: dec_op = OP_SLTU;
                        3'b100: dec_op = OP_XOR;
                        3'b101: dec_op = OP_SRL;
                        3'b110: dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec_op = OP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec_op = OP_SRA;
                end else begin
                    dec_op = OP_NOP; dec_wr = 1'b0;
                end
            end
            default: begin
                dec_op = OP_NOP;
            end
        endcase
    end

    // Read ports are quiet when IF/ID is empty
    assign re1    = in_valid & use1;
    assign re2    = in_valid & use2;
    assign raddr1 = in_valid ? in_inst[19:15] : '0;
    assign raddr2 = in_valid ? in_inst[24:20] : '0;

    // A load in EX has no data yet, so it is never an EX forward source
    always_comb begin
        fwd1 = rdata1;
        if (!re1 || raddr1 == '0)
            fwd1 = '0;
        else if (ex_wreg && ex_waddr == raddr1 && !ex_is_load)
            fwd1 = ex_wdata;
        else if (mem_wreg && mem_waddr == raddr1)
            fwd1 = mem_wdata;
    end

    always_comb begin
        fwd2 = rdata2;
        if (!re2 || raddr2 == '0)
            fwd2 = '0;
        else if (ex_wreg && ex_waddr == raddr2 && !ex_is_load)
            fwd2 = ex_wdata;
        else if (mem_wreg && mem_waddr == raddr2)
            fwd2 = mem_wdata;
    end

    assign lu = in_valid & ex_is_load & ex_wreg & (ex_waddr != '0) &
                ((re1 & (ex_waddr == raddr1)) | (re2 & (ex_waddr == raddr2)));

    assign stall_req = in_valid & (ex_stall | lu) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op      <= OP_NOP;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_wreg    <= 1'b0;
            out_waddr   <= '0;
        end else if (!rdy) begin
            // frozen
        end else if (flush) begin
            out_valid <= 1'b0;
            out_wreg  <= 1'b0;
        end else if (ex_stall) begin
            // EX still owns the current slot
        end else if (lu) begin
            out_valid <= 1'b0;
            out_wreg  <= 1'b0;
        end else begin
            out_valid   <= in_valid;
            out_pc      <= in_pc;
            out_op      <= dec_op;
            out_rs1_val <= fwd1;
            out_rs2_val <= fwd2;
            out_imm     <= dec_imm;
            out_wreg    <= in_valid & dec_wr & (rd != '0);
            out_waddr   <= rd;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none

module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, rdy, in_valid, flush, ex_stall;
    logic [31:0] in_pc, in_inst, rdata1, rdata2, ex_wdata, mem_wdata;
    logic        stall_req, re1, re2;
    logic [4:0]  raddr1, raddr2, ex_waddr, mem_waddr, out_waddr;
    logic        ex_wreg, ex_is_load, mem_wreg;
    logic        out_valid, out_wreg;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [5:0]  out_op;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_pc(in_pc),
        .in_inst(in_inst), .flush(flush), .ex_stall(ex_stall),
        .stall_req(stall_req), .re1(re1), .re2(re2), .raddr1(raddr1),
        .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2), .ex_wreg(ex_wreg),
        .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_op(out_op),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_wreg(out_wreg), .out_waddr(out_waddr)
    );

    task automatic quiet();
        rst = 0; rdy = 1; in_valid = 0; in_pc = 0; in_inst = 0; flush = 0;
        ex_stall = 0; rdata1 = 0; rdata2 = 0; ex_wreg = 0; ex_waddr = 0;
        ex_wdata = 0; ex_is_load = 0; mem_wreg = 0; mem_waddr = 0; mem_wdata = 0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_op !== 6'd0) begin errors++; $display("FAIL reset_op got=%0d exp=0", out_op); end
        checks++; if (out_imm !== 32'd0 || out_wreg !== 1'b0) begin errors++; $display("FAIL reset_imm_wreg got=%h/%0b exp=0/0", out_imm, out_wreg); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
        rst = 0;
    endtask

    task automatic test_addi();
        quiet();
        in_valid = 1; in_pc = 32'h100; in_inst = 32'h00500093;
        #1;
        checks++; if (re1 !== 1'b1 || re2 !== 1'b0 || raddr1 !== 5'd0) begin errors++; $display("FAIL addi_reads got=%0b%0b/%0d exp=10/0", re1, re2, raddr1); end
        step();
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'd5) begin errors++; $display("FAIL addi_out got=%0b/%h exp=1/00000005", out_valid, out_imm); end
        checks++; if (out_waddr !== 5'd1 || out_wreg !== 1'b1 || out_op !== 6'd19) begin errors++; $display("FAIL addi_rd got=%0d/%0b/%0d exp=1/1/19", out_waddr, out_wreg, out_op); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got=%h exp=00000100", out_pc); end
    endtask

    task automatic test_forward();
        quiet();
        in_valid = 1; in_inst = 32'h002081B3;
        ex_wreg = 1; ex_waddr = 1; ex_wdata = 7;
        mem_wreg = 1; mem_waddr = 1; mem_wdata = 9; rdata1 = 32'h33; rdata2 = 32'h22;
        step();
        checks++; if (out_rs1_val !== 32'd7) begin errors++; $display("FAIL fwd_ex got=%h exp=00000007", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'h22 || out_op !== 6'd28) begin errors++; $display("FAIL fwd_rdata got=%h/%0d exp=00000022/28", out_rs2_val, out_op); end
        ex_wreg = 0;
        step();
        checks++; if (out_rs1_val !== 32'd9) begin errors++; $display("FAIL fwd_mem got=%h exp=00000009", out_rs1_val); end
        mem_wreg = 0;
        step();
        checks++; if (out_rs1_val !== 32'h33) begin errors++; $display("FAIL fwd_none got=%h exp=00000033", out_rs1_val); end
    endtask

    task automatic test_load_use();
        quiet();
        in_valid = 1; in_inst = 32'h00528333;
        ex_is_load = 1; ex_wreg = 1; ex_waddr = 5; ex_wdata = 32'hDEAD;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", stall_req); end
        step();
        checks++; if (out_valid !== 1'b0 || out_wreg !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%0b/%0b exp=0/0", out_valid, out_wreg); end
        ex_is_load = 0; ex_wreg = 0; ex_waddr = 0;
        mem_wreg = 1; mem_waddr = 5; mem_wdata = 32'h11;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lu_release got=%0b exp=0", stall_req); end
        step();
        checks++; if (out_rs1_val !== 32'h11 || out_rs2_val !== 32'h11) begin errors++; $display("FAIL lu_memfwd got=%h/%h exp=00000011/00000011", out_rs1_val, out_rs2_val); end
        checks++; if (out_valid !== 1'b1 || out_waddr !== 5'd6) begin errors++; $display("FAIL lu_issue got=%0b/%0d exp=1/6", out_valid, out_waddr); end
    endtask

    task automatic test_x0();
        quiet();
        in_valid = 1; in_inst = 32'h00100013;
        ex_wreg = 1; ex_waddr = 0; ex_wdata = 32'hFF; rdata1 = 32'h55;
        step();
        checks++; if (out_rs1_val !== 32'd0) begin errors++; $display("FAIL x0_val got=%h exp=00000000", out_rs1_val); end
        checks++; if (out_wreg !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL x0_wreg got=%0b/%0b exp=0/1", out_wreg, out_valid); end
    endtask

    task automatic test_flush_hold();
        quiet();
        in_valid = 1; in_inst = 32'h00500093;
        step();
        flush = 1; ex_stall = 1;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_stallreq got=%0b exp=0", stall_req); end
        step();
        checks++; if (out_valid !== 1'b0 || out_wreg !== 1'b0) begin errors++; $display("FAIL flush_wins got=%0b/%0b exp=0/0", out_valid, out_wreg); end
        flush = 0; ex_stall = 0;
        step();
        rdy = 0; in_inst = 32'hFE000EE3; in_pc = 32'h200;
        step(); step();
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'd5 || out_pc !== 32'h0) begin errors++; $display("FAIL rdy_hold got=%0b/%h/%h exp=1/00000005/00000000", out_valid, out_imm, out_pc); end
        rdy = 1; ex_stall = 1;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL exstall_req got=%0b exp=1", stall_req); end
        step();
        checks++; if (out_imm !== 32'd5 || out_op !== 6'd19) begin errors++; $display("FAIL exstall_hold got=%h/%0d exp=00000005/19", out_imm, out_op); end
        rst = 1;
        step();
        checks++; if (out_valid !== 1'b0 || out_imm !== 32'd0) begin errors++; $display("FAIL rst_midstall got=%0b/%h exp=0/00000000", out_valid, out_imm); end
        rst = 0;
    endtask

    task automatic test_imm_forms();
        quiet();
        in_valid = 1; in_inst = 32'hFE000EE3;
        #1;
        checks++; if (re1 !== 1'b1 || re2 !== 1'b1) begin errors++; $display("FAIL beq_reads got=%0b%0b exp=11", re1, re2); end
        step();
        checks++; if (out_imm !== 32'hFFFFFFFC || out_wreg !== 1'b0 || out_op !== 6'd5) begin errors++; $display("FAIL beq_out got=%h/%0b/%0d exp=fffffffc/0/5", out_imm, out_wreg, out_op); end
        in_inst = 32'h12345137;
        #1;
        checks++; if (re1 !== 1'b0 || re2 !== 1'b0) begin errors++; $display("FAIL lui_reads got=%0b%0b exp=00", re1, re2); end
        step();
        checks++; if (out_imm !== 32'h12345000 || out_op !== 6'd1 || out_waddr !== 5'd2 || out_wreg !== 1'b1) begin errors++; $display("FAIL lui_out got=%h/%0d/%0d/%0b exp=12345000/1/2/1", out_imm, out_op, out_waddr, out_wreg); end
        in_inst = 32'h008000EF;
        step();
        checks++; if (out_imm !== 32'd8 || out_op !== 6'd3 || out_wreg !== 1'b1) begin errors++; $display("FAIL jal_out got=%h/%0d/%0b exp=00000008/3/1", out_imm, out_op, out_wreg); end
        in_inst = 32'h0000007F;
        step();
        checks++; if (out_valid !== 1'b1 || out_op !== 6'd0 || out_wreg !== 1'b0) begin errors++; $display("FAIL unknown_out got=%0b/%0d/%0b exp=1/0/0", out_valid, out_op, out_wreg); end
        in_valid = 0;
        #1;
        checks++; if (re1 !== 1'b0 || raddr1 !== 5'd0 || raddr2 !== 5'd0) begin errors++; $display("FAIL idle_reads got=%0b/%0d/%0d exp=0/0/0", re1, raddr1, raddr2); end
        step();
        checks++; if (out_valid !== 1'b0 || out_wreg !== 1'b0) begin errors++; $display("FAIL idle_out got=%0b/%0b exp=0/0", out_valid, out_wreg); end
    endtask

    initial begin
        quiet();
        @(negedge clk);
        test_reset();
        test_addi();
        test_forward();
        test_load_use();
        test_x0();
        test_flush_hold();
        test_imm_forms();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
